// File: rtl/ex_stage.sv
// TinyRISC execute stage: ALU, flags, branch resolution, iterative signed divider
// and the EX/MA pipeline register.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] instruction_in,
    input  logic [21:0] ControlWord_in,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] immx,
    input  logic [31:0] branchTarget_in,
    output logic        stall,
    output logic        isBranchTaken,
    output logic [31:0] branchPC,
    output logic        valid,
    output logic [31:0] PC,
    output logic [31:0] instruction_MA,
    output logic [21:0] ControlWord,
    output logic [31:0] aluResult,
    output logic [31:0] op2_out
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t  r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo, r_rem, r_dvs;
    logic        r_neg_q, r_neg_r, r_dvs_zero;
    logic        r_flag_e, r_flag_gt;

    logic        w_is_add, w_is_sub, w_is_cmp, w_is_mul, w_is_div, w_is_mod;
    logic        w_is_lsl, w_is_lsr, w_is_asr, w_is_or, w_is_st, w_is_ld;
    logic        w_is_and, w_is_not, w_is_mov, w_is_imm;
    logic        w_is_beq, w_is_bgt, w_is_ubr, w_is_ret, w_is_call;
    logic [31:0] w_b, w_alu, w_result, w_abs_a, w_abs_b, w_q_final, w_r_final;
    logic [32:0] w_rem_sh, w_rem_diff;
    logic        w_divop, w_start;

    assign w_is_add  = ControlWord_in[0];
    assign w_is_sub  = ControlWord_in[1];
    assign w_is_cmp  = ControlWord_in[2];
    assign w_is_mul  = ControlWord_in[3];
    assign w_is_div  = ControlWord_in[4];
    assign w_is_mod  = ControlWord_in[5];
    assign w_is_lsl  = ControlWord_in[6];
    assign w_is_lsr  = ControlWord_in[7];
    assign w_is_asr  = ControlWord_in[8];
    assign w_is_or   = ControlWord_in[9];
    assign w_is_st   = ControlWord_in[10];
    assign w_is_ld   = ControlWord_in[11];
    assign w_is_and  = ControlWord_in[12];
    assign w_is_not  = ControlWord_in[13];
    assign w_is_mov  = ControlWord_in[14];
    assign w_is_imm  = ControlWord_in[16];
    assign w_is_beq  = ControlWord_in[17];
    assign w_is_bgt  = ControlWord_in[18];
    assign w_is_ubr  = ControlWord_in[19];
    assign w_is_ret  = ControlWord_in[20];
    assign w_is_call = ControlWord_in[21];

    assign w_b     = w_is_imm ? immx : op2;
    assign w_divop = w_is_div | w_is_mod;
    assign w_start = (r_state == S_IDLE) & valid_in & w_divop;
    assign stall   = w_start | (r_state == S_BUSY);

    assign isBranchTaken = valid_in & ~stall &
                           (w_is_ubr | w_is_call | w_is_ret |
                            (w_is_beq & r_flag_e) | (w_is_bgt & r_flag_gt));
    assign branchPC = w_is_ret ? op1 : branchTarget_in;

    always_comb begin
        w_alu = '0;
        if (w_is_add | w_is_ld | w_is_st) w_alu = op1 + w_b;
        else if (w_is_sub)  w_alu = op1 - w_b;
        else if (w_is_mul)  w_alu = op1 * w_b;
        else if (w_is_and)  w_alu = op1 & w_b;
        else if (w_is_or)   w_alu = op1 | w_b;
        else if (w_is_not)  w_alu = ~w_b;
        else if (w_is_mov)  w_alu = w_b;
        else if (w_is_lsl)  w_alu = op1 << w_b[4:0];
        else if (w_is_lsr)  w_alu = op1 >> w_b[4:0];
        else if (w_is_asr)  w_alu = $signed(op1) >>> w_b[4:0];
        else if (w_is_call) w_alu = PC_in + 32'd4;
    end

    // Restoring divider on magnitudes; signs are reapplied once all 32 steps are done.
    assign w_abs_a    = op1[31] ? -op1 : op1;
    assign w_abs_b    = w_b[31] ? -w_b : w_b;
    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_dvs};
    assign w_q_final  = r_dvs_zero ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_r_final  = r_neg_r ? -r_rem : r_rem;

    assign w_result = w_divop ? ((r_state == S_DONE) ? (w_is_div ? w_q_final : w_r_final) : '0)
                              : w_alu;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dvs_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_quo      <= w_abs_a;
                r_rem      <= '0;
                r_dvs      <= w_abs_b;
                r_neg_q    <= op1[31] ^ w_b[31];
                r_neg_r    <= op1[31];
                r_dvs_zero <= (w_b == '0);
                r_cnt      <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 5'd1;
                r_quo <= {r_quo[30:0], ~w_rem_diff[32]};
                r_rem <= w_rem_diff[32] ? w_rem_sh[31:0] : w_rem_diff[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_e  <= 1'b0;
            r_flag_gt <= 1'b0;
        end else if (valid_in & ~stall & w_is_cmp) begin
            r_flag_e  <= (op1 == w_b);
            r_flag_gt <= ($signed(op1) > $signed(w_b));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid          <= 1'b0;
            PC             <= '0;
            instruction_MA <= '0;
            ControlWord    <= '0;
            aluResult      <= '0;
            op2_out        <= '0;
        end else if (stall | ~valid_in) begin
            valid          <= 1'b0;
            PC             <= '0;
            instruction_MA <= '0;
            ControlWord    <= '0;
            aluResult      <= '0;
            op2_out        <= '0;
        end else begin
            valid          <= 1'b1;
            PC             <= PC_in;
            instruction_MA <= instruction_in;
            ControlWord    <= ControlWord_in;
            aluResult      <= w_result;
            op2_out        <= op2;
        end
    end

endmodule
